// File: rtl/keypad_decoder.sv
// Debounced 4x4 keypad decoder: one-hot row/column scan code in, hex key code plus press strobe/held flag out.
// Define KEY_HISTORY_EN to enable the two-digit history registers (digit_new/digit_old). DEBOUNCE_CYCLES >= 2.
module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_val,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    cand;
  logic          blocked;
  logic          sample_valid;
  logic          accept;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] bit_index(input logic [3:0] v);
    case (v)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] hex_of(input logic [7:0] v);
    case ({bit_index(v[7:4]), bit_index(v[3:0])})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // Anything that is not exactly one row and one column is treated as "no key".
  assign sample_valid = is_onehot(key_val[7:4]) && is_onehot(key_val[3:0]);
  assign cnt_inc      = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
  assign accept       = (state == PRESS_DB) && sample_valid && (key_val == cand) && (cnt_inc == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      blocked   <= 1'b0;
      key_code  <= '0;
      key_pulse <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            cand  <= key_val;
            cnt   <= '0;
            state <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (!sample_valid) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (key_val != cand) begin
            cand <= key_val;
            cnt  <= '0;
          end else if (accept) begin
            cnt       <= '0;
            key_code  <= hex_of(cand);
            key_pulse <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          // The leaving sample is the first release sample when it is a no-key.
          if (key_val != cand) begin
            cnt     <= '0;
            blocked <= sample_valid;
            state   <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (sample_valid && (key_val == cand)) begin
            cnt     <= '0;
            blocked <= 1'b0;
            state   <= HELD;
          end else if (sample_valid) begin
            cnt     <= '0;
            blocked <= 1'b1;
          end else if (blocked) begin
            cnt     <= '0;
            blocked <= 1'b0;
          end else if (cnt_inc == LAST) begin
            cnt      <= '0;
            key_held <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_HISTORY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_new <= '0;
      digit_old <= '0;
    end else if (accept) begin
      digit_new <= hex_of(cand);
      digit_old <= digit_new;
    end
  end
`else
  assign digit_new = 4'd0;
  assign digit_old = 4'd0;
`endif

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder with DEBOUNCE_CYCLES=4; digit checks follow KEY_HISTORY_EN.
module tb_keypad_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_val;
  logic [3:0] key_code;
  logic       key_pulse;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
    logic [3:0] dn;
    logic [3:0] dold;
  } exp_t;

  exp_t       q[$];
  logic [3:0] hist_new = 4'd0;
  logic [3:0] hist_old = 4'd0;
  logic       prev_pulse = 1'b0;

  keypad_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_val  (key_val),
    .key_code (key_code),
    .key_pulse(key_pulse),
    .key_held (key_held),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected press: code visible with a pulse at monitor cycle 'at'.
  task automatic expect_press(input logic [3:0] code, input int at);
    exp_t e;
    hist_old = hist_new;
    hist_new = code;
    e.code = code;
    e.at   = at;
`ifdef KEY_HISTORY_EN
    e.dn   = hist_new;
    e.dold = hist_old;
`else
    e.dn   = 4'd0;
    e.dold = 4'd0;
`endif
    q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] val, input int n);
    repeat (n) begin
      key_val = val;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key_code"}, 32'(key_code), 32'h0);
    chk({tag, "_key_pulse"}, 32'(key_pulse), 32'h0);
    chk({tag, "_key_held"}, 32'(key_held), 32'h0);
    chk({tag, "_digit_new"}, 32'(digit_new), 32'h0);
    chk({tag, "_digit_old"}, 32'(digit_old), 32'h0);
  endtask

  // Monitor: every pulse pops one expectation and checks code, timing and history.
  always @(negedge clk) begin
    if (reset === 1'b1 && key_pulse === 1'b1) begin
      chk("pulse_not_consecutive", 32'(prev_pulse), 32'h0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual=code %0h at cycle %0d required=no pulse", key_code, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.at));
        chk("pulse_code", 32'(key_code), 32'(e.code));
        chk("pulse_digit_new", 32'(digit_new), 32'(e.dn));
        chk("pulse_digit_old", 32'(digit_old), 32'(e.dold));
      end
    end
    prev_pulse = key_pulse;
  end

  initial begin
    int c;
    key_val = 8'h00;
    reset   = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Clean press of key 1 held 6 cycles, then full release.
    c = cyc;
    expect_press(4'h1, c + 4);
    drive(8'h11, 6);
    chk("t1_key_held", 32'(key_held), 32'h1);
    chk("t1_key_code", 32'(key_code), 32'h1);
    drive(8'h00, 3);
    chk("t1_held_after_3_zero", 32'(key_held), 32'h1);
    drive(8'h00, 1);
    chk("t1_held_after_4_zero", 32'(key_held), 32'h0);

    // Short bounce on key D: never accepted.
    drive(8'h88, 2);
    drive(8'h00, 2);
    chk("t2_key_held", 32'(key_held), 32'h0);
    chk("t2_key_code", 32'(key_code), 32'h1);

    // Key 6 with a one-cycle release glitch: single pulse.
    c = cyc;
    expect_press(4'h6, c + 4);
    drive(8'h24, 4);
    drive(8'h00, 1);
    drive(8'h24, 1);
    drive(8'h00, 3);
    chk("t3_held_after_3_zero", 32'(key_held), 32'h1);
    drive(8'h00, 1);
    chk("t3_held_after_4_zero", 32'(key_held), 32'h0);
    chk("t3_key_code", 32'(key_code), 32'h6);

    // Key 1 then key 0, each with full release.
    c = cyc;
    expect_press(4'h1, c + 4);
    drive(8'h11, 5);
    drive(8'h00, 4);
    c = cyc;
    expect_press(4'h0, c + 4);
    drive(8'h82, 5);
    drive(8'h00, 4);
    chk("t4_key_code", 32'(key_code), 32'h0);
`ifdef KEY_HISTORY_EN
    chk("t4_digit_new", 32'(digit_new), 32'h0);
    chk("t4_digit_old", 32'(digit_old), 32'h1);
`else
    chk("t4_digit_new", 32'(digit_new), 32'h0);
    chk("t4_digit_old", 32'(digit_old), 32'h0);
`endif

    // Two rows pressed: invalid, treated as no key.
    drive(8'h31, 10);
    chk("t5_key_held", 32'(key_held), 32'h0);
    chk("t5_key_code", 32'(key_code), 32'h0);
    drive(8'h00, 1);

    // Candidate switches during press debounce: only key 7 accepted.
    c = cyc;
    expect_press(4'h7, c + 6);
    drive(8'h11, 2);
    drive(8'h41, 4);
    drive(8'h00, 4);
    chk("t6_key_held", 32'(key_held), 32'h0);

    // Second key during release debounce: no rollover, release restarts.
    c = cyc;
    expect_press(4'h1, c + 4);
    drive(8'h11, 4);
    drive(8'h82, 3);
    drive(8'h00, 3);
    chk("t7_held_after_3_zero", 32'(key_held), 32'h1);
    drive(8'h00, 1);
    chk("t7_held_after_4_zero", 32'(key_held), 32'h0);
    chk("t7_key_code", 32'(key_code), 32'h1);

    // Reset during hold of key 9, key stays pressed across reset.
    c = cyc;
    expect_press(4'h9, c + 4);
    drive(8'h44, 5);
    chk("t8_key_held", 32'(key_held), 32'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("t8_async_reset");
    hist_new = 4'd0;
    hist_old = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    c = cyc;
    expect_press(4'h9, c + 4);
    drive(8'h44, 6);
    chk("t8_key_code", 32'(key_code), 32'h9);
    drive(8'h00, 4);
    chk("t8_key_held", 32'(key_held), 32'h0);

    drive(8'h00, 4);
    chk("all_pulses_seen", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive identical samples required to accept a press or release.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 key_val  input  8  raw scanner code; [7:4] one-hot row, [3:0] one-hot column; 0 = no key.
REQ-006 key_code  output  4  hex value of the accepted key; holds until the next accepted press.
REQ-007 key_pulse  output  1  one-cycle strobe per accepted press.
REQ-008 key_held  output  1  high from the accepted press until the accepted release.
REQ-009 digit_new  output  4  most recent accepted key (history feature).
REQ-010 digit_old  output  4  previous accepted key (history feature).

Function
REQ-011 Valid code: exactly one bit set in [7:4] and exactly one in [3:0]; any other nonzero pattern SHALL be treated as no key.
REQ-012 Map row r (bit 4+r) and column c (bit c), indexed [r][c]: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
REQ-013 States SHALL be IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-014 IDLE: a valid code SHALL latch as candidate, clear the counter and go to PRESS_DB.
REQ-015 PRESS_DB: the counter SHALL increment each cycle key_val equals the candidate.
REQ-016 PRESS_DB: on a different valid code, the candidate SHALL reload and the counter restart; on no key, return to IDLE.
REQ-017 PRESS_DB: when the counter reaches DEBOUNCE_CYCLES-1 with a matching sample, the next edge SHALL enter HELD, update key_code, assert key_pulse for exactly one cycle and set key_held.
REQ-018 HELD: the same code SHALL stay in HELD; any other value SHALL enter RELEASE_DB with the counter cleared.
REQ-019 RELEASE_DB: DEBOUNCE_CYCLES consecutive no-key samples SHALL enter IDLE and clear key_held.
REQ-020 RELEASE_DB: reappearance of the held code SHALL return to HELD with no new pulse.
REQ-021 RELEASE_DB: a different valid code SHALL restart the counter; no rollover, and the second key is not accepted until a full release.
REQ-022 The counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 and SHALL saturate, never wrap.
REQ-023 key_pulse SHALL never be asserted on two consecutive cycles.

Reset
REQ-024 Reset assertion SHALL force IDLE, counter 0, candidate 0, key_code 0, key_pulse 0, key_held 0, digit_new 0 and digit_old 0, without waiting for a clock edge.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; no pulse after deassertion until a fresh full debounce.

Configuration
REQ-026 Macro KEY_HISTORY_EN, when defined, SHALL enable the two-digit history.
REQ-027 With KEY_HISTORY_EN, on each key_pulse cycle digit_old SHALL take digit_new and digit_new SHALL take the new key_code, both in the same cycle as the pulse.
REQ-028 Without KEY_HISTORY_EN, the digit_new and digit_old ports SHALL remain present, tied to 0, with no history registers.

Verification (DEBOUNCE_CYCLES=4, KEY_HISTORY_EN defined)
REQ-029 key_val=8'b0001_0001 held 6 cycles from IDLE -> key_pulse high in exactly one cycle (4th edge after first sample); key_code=4'h1; key_held=1.
REQ-030 key_val=8'b1000_1000 held 2 cycles, then 0 -> no key_pulse; state returns to IDLE.
REQ-031 Press 8'b0010_0100 (6) for 4 cycles, 0 for 1 cycle, 8'b0010_0100 again, then 0 for 4 cycles -> exactly one pulse; key_held falls after the 4th zero sample.
REQ-032 Press 8'b0001_0001, release fully, then press 8'b1000_0010 -> key_code 1 then 0; final digit_old=4'h1, digit_new=4'h0.
REQ-033 key_val=8'b0011_0001 (two rows) for 10 cycles -> no pulse; key_held=0.
REQ-034 Reset driven low during HELD of key 9 -> all outputs 0 immediately; after reset deasserts with key still pressed, a new pulse only after 4 cycles.
